// File: rtl/dds_mix_pkg.sv
// ---------------------------------------------------------------------------
// dds_mix_pkg
// Shared constants and types for the DDS voice mixer.
//   NVOICE    number of voices mixed per frame (one per clock)
//   VOICE_W   voice sample / mix width, offset-binary
//   GAIN_W    per-voice gain width, unsigned Q2.2
//   GAIN_FRAC fractional bits of the gain (shift applied to each product)
//   MID       offset-binary zero
//   GAIN_RST  gain value loaded by reset (0.25)
// ---------------------------------------------------------------------------
package dds_mix_pkg;

  localparam int NVOICE    = 4;
  localparam int VOICE_W   = 12;
  localparam int GAIN_W    = 4;
  localparam int GAIN_FRAC = 2;
  localparam int ACC_W     = VOICE_W + GAIN_W;

  localparam logic [VOICE_W-1:0] MID      = 12'h800;
  localparam logic [GAIN_W-1:0]  GAIN_RST = 4'd1;

  // Frame phase: phase k processes voice k.
  typedef logic [1:0] phase_t;

  // Signed product / accumulator. Four worst-case terms span
  // -30720..30704, so VOICE_W+GAIN_W bits never overflow.
  typedef logic signed [ACC_W-1:0] acc_t;

endpackage

// File: rtl/dds_dsm1.sv
// ---------------------------------------------------------------------------
// dds_dsm1
// First-order delta-sigma 1-bit DAC. Every cycle the low W bits of the
// accumulator are added to din; the carry out is the output bit, so the
// ones density equals din / 2^W.
// Only built when DDS_MIXER_DSM_EN is defined.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset (clears accumulator and output)
//   din   unsigned level to modulate (W bits)
//   dout  1-bit bitstream
// ---------------------------------------------------------------------------
`ifdef DDS_MIXER_DSM_EN
module dds_dsm1
  import dds_mix_pkg::*;
#(
  parameter int W = VOICE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic         dout
);

  // Bit W of the accumulator holds the carry of the last addition and is
  // the registered output bit.
  logic [W:0] ds_acc_q;
  logic [W:0] ds_acc_d;

  always_comb begin
    ds_acc_d = {1'b0, ds_acc_q[W-1:0]} + {1'b0, din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ds_acc_q <= '0;
    end else begin
      ds_acc_q <= ds_acc_d;
    end
  end

  assign dout = ds_acc_q[W];

endmodule
`endif

// File: rtl/dds_voice_mixer.sv
// ---------------------------------------------------------------------------
// dds_voice_mixer
// Time-multiplexed four-voice mixer. A single multiply-accumulate handles
// one voice per clock over a 4-cycle frame; each voice is scaled by its own
// unsigned Q2.2 gain and the frame sum is saturated to W bits.
// Build option: DDS_MIXER_DSM_EN adds a first-order delta-sigma DAC on the
// registered mix; without it dac_out is tied low (ports unchanged).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   voice0..voice3   offset-binary voice samples (voice k sampled in phase k)
//   gain_we          gain write strobe
//   gain_addr        voice index of the gain write
//   gain_data        new gain (Q2.2, 4 = unity)
//   mix_out          registered saturated mix, offset-binary
//   mix_valid        one-cycle pulse, high during phase 0 after an update
//   dac_out          delta-sigma bitstream (0 when the DAC is not built)
// ---------------------------------------------------------------------------
module dds_voice_mixer
  import dds_mix_pkg::*;
#(
  parameter int W  = VOICE_W,
  parameter int GW = GAIN_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  voice0,
  input  logic [W-1:0]  voice1,
  input  logic [W-1:0]  voice2,
  input  logic [W-1:0]  voice3,
  input  logic          gain_we,
  input  logic [1:0]    gain_addr,
  input  logic [GW-1:0] gain_data,
  output logic [W-1:0]  mix_out,
  output logic          mix_valid,
  output logic          dac_out
);

  localparam acc_t SAT_HI = acc_t'((1 << (W-1)) - 1);
  localparam acc_t SAT_LO = acc_t'(-(1 << (W-1)));

  logic [W-1:0]  voice_arr [NVOICE];
  logic [GW-1:0] gain_q    [NVOICE];
  logic [GW-1:0] gain_d    [NVOICE];

  phase_t              phase_q, phase_d;
  acc_t                acc_q, acc_d;
  logic [W-1:0]        mix_q, mix_d;
  logic                mix_valid_q, mix_valid_d;

  logic [W-1:0]        voice_sel;
  logic signed [W-1:0] voice_s;
  acc_t                prod;
  acc_t                term;
  acc_t                sum;
  logic [W-1:0]        sat;

  assign voice_arr[0] = voice0;
  assign voice_arr[1] = voice1;
  assign voice_arr[2] = voice2;
  assign voice_arr[3] = voice3;

  // Gain file: the MAC reads gain_q, so a write only takes effect from the
  // cycle after the strobe.
  always_comb begin
    for (int i = 0; i < NVOICE; i++) begin
      gain_d[i] = gain_q[i];
      if (gain_we && (gain_addr == 2'(i))) begin
        gain_d[i] = gain_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NVOICE; i++) begin
      if (rst) begin
        gain_q[i] <= GW'(GAIN_RST);
      end else begin
        gain_q[i] <= gain_d[i];
      end
    end
  end

  always_comb begin
    voice_sel = voice_arr[phase_q];
    // Offset-binary to two's complement: flip the MSB.
    voice_s   = $signed({~voice_sel[W-1], voice_sel[W-2:0]});
    // Gain is unsigned; the leading zero keeps it positive in signed math.
    prod      = acc_t'(voice_s) * acc_t'($signed({1'b0, gain_q[phase_q]}));
    term      = prod >>> GAIN_FRAC;
    sum       = acc_q + term;

    if (sum > SAT_HI) begin
      sat = {1'b0, {(W-1){1'b1}}};
    end else if (sum < SAT_LO) begin
      sat = {1'b1, {(W-1){1'b0}}};
    end else begin
      sat = sum[W-1:0];
    end

    phase_d     = phase_q + phase_t'(1);
    acc_d       = acc_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;

    unique case (phase_q)
      2'd0: acc_d = term;
      2'd1,
      2'd2: acc_d = sum;
      default: begin
        // Last voice: fold its term straight into the output register.
        acc_d       = '0;
        mix_d       = {~sat[W-1], sat[W-2:0]};
        mix_valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= '0;
      acc_q       <= '0;
      mix_q       <= W'(MID);
      mix_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
    end
  end

  assign mix_out   = mix_q;
  assign mix_valid = mix_valid_q;

`ifdef DDS_MIXER_DSM_EN
  dds_dsm1 #(
    .W (W)
  ) u_dsm (
    .clk  (clk),
    .rst  (rst),
    .din  (mix_q),
    .dout (dac_out)
  );
`else
  assign dac_out = 1'b0;
`endif

endmodule

// File: tb/tb_dds_voice_mixer.sv
// ---------------------------------------------------------------------------
// tb_dds_voice_mixer
// Self-checking bench for dds_voice_mixer. A frame-level reference model
// records which voice sample and gain are in effect in each phase and
// computes the expected mix from the mixing rules with integer arithmetic.
// The delta-sigma expectation is an integer overflow-count model.
// ---------------------------------------------------------------------------
module tb_dds_voice_mixer;

`ifdef DDS_MIXER_DSM_EN
  localparam bit DSM_EN = 1'b1;
`else
  localparam bit DSM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] vin [4];
  logic        gain_we;
  logic [1:0]  gain_addr;
  logic [3:0]  gain_data;
  logic [11:0] mix_out;
  logic        mix_valid;
  logic        dac_out;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int          ph;
  int          gm [4];
  logic [11:0] smp [4];
  int          sg [4];
  logic [11:0] exp_mix;
  logic        exp_valid;
  logic        exp_dac;
  int          ds_low;

  always #5 clk = ~clk;

  dds_voice_mixer dut (
    .clk       (clk),
    .rst       (rst),
    .voice0    (vin[0]),
    .voice1    (vin[1]),
    .voice2    (vin[2]),
    .voice3    (vin[3]),
    .gain_we   (gain_we),
    .gain_addr (gain_addr),
    .gain_data (gain_data),
    .mix_out   (mix_out),
    .mix_valid (mix_valid),
    .dac_out   (dac_out)
  );

  function automatic int floor4(input int p);
    if (p >= 0) return p / 4;
    return -((-p + 3) / 4);
  endfunction

  // Mix of one frame: sum of floor(signed_voice * gain / 4), clamped.
  function automatic logic [11:0] mix_model(input logic [11:0] v [4], input int g [4]);
    int total = 0;
    for (int k = 0; k < 4; k++) begin
      total += floor4((int'(v[k]) - 2048) * g[k]);
    end
    if (total > 2047)  total = 2047;
    if (total < -2048) total = -2048;
    return 12'(total + 2048);
  endfunction

  // One clock edge; the model consumes the inputs seen at that edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      ph        = 0;
      for (int k = 0; k < 4; k++) gm[k] = 1;
      exp_mix   = 12'h800;
      exp_valid = 1'b0;
      exp_dac   = 1'b0;
      ds_low    = 0;
    end else begin
      ds_low  = ds_low + int'(exp_mix);
      exp_dac = DSM_EN ? (ds_low >= 4096) : 1'b0;
      ds_low  = ds_low % 4096;
      smp[ph] = vin[ph];
      sg[ph]  = gm[ph];
      exp_valid = (ph == 3);
      if (ph == 3) exp_mix = mix_model(smp, sg);
      if (gain_we) gm[gain_addr] = int'(gain_data);
      ph = (ph + 1) % 4;
    end
    #1;
  endtask

  task automatic wr_gain(input int a, input int d);
    gain_we   = 1'b1;
    gain_addr = 2'(a);
    gain_data = 4'(d);
    step();
    gain_we   = 1'b0;
  endtask

  task automatic align();
    while (ph != 0) step();
  endtask

  task automatic set_all(input logic [11:0] v);
    for (int k = 0; k < 4; k++) vin[k] = v;
  endtask

  task automatic test_reset();
    set_all(12'h800);
    rst = 1'b1;
    step();
    step();
    vectors++;
    if (mix_out !== 12'h800) begin
      errors++; $display("FAIL reset_mix: got %h want 800", mix_out);
    end
    vectors++;
    if (mix_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", mix_valid);
    end
    vectors++;
    if (dac_out !== 1'b0) begin
      errors++; $display("FAIL reset_dac: got %b want 0", dac_out);
    end
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      vectors++;
      if (mix_valid !== ((i % 4) == 0)) begin
        errors++; $display("FAIL valid_latency edge %0d: got %b want %b", i, mix_valid, (i % 4) == 0);
      end
    end
    $display("reset: first mix_valid at edge 4 after deassert, period 4 checked");
  endtask

  task automatic test_unity_max();
    set_all(12'hFFF);
    align();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) step();
      vectors++;
      if (mix_valid !== 1'b1 || mix_out !== 12'hFFC) begin
        errors++; $display("FAIL unity_max: got valid=%b mix=%h want valid=1 mix=ffc", mix_valid, mix_out);
      end
      $display("unity_max frame %0d: mix=%h", f, mix_out);
    end
  endtask

  task automatic test_single_voice();
    wr_gain(0, 4); wr_gain(1, 0); wr_gain(2, 0); wr_gain(3, 0);
    align();
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < 4; j++) vin[j] = 12'($urandom_range(0, 4095));
        vin[0] = 12'hC00;
        step();
      end
      vectors++;
      if (mix_valid !== 1'b1 || mix_out !== 12'hC00 || mix_out !== exp_mix) begin
        errors++; $display("FAIL single_voice: got valid=%b mix=%h want valid=1 mix=c00", mix_valid, mix_out);
      end
      $display("single_voice frame %0d: mix=%h", f, mix_out);
    end
  endtask

  task automatic test_saturation();
    logic [11:0] pats [2];
    logic [11:0] want [2];
    pats[0] = 12'hFFF; want[0] = 12'hFFF;
    pats[1] = 12'h000; want[1] = 12'h000;
    for (int k = 0; k < 4; k++) wr_gain(k, 15);
    for (int p = 0; p < 2; p++) begin
      set_all(pats[p]);
      align();
      for (int f = 0; f < 2; f++) begin
        for (int k = 0; k < 4; k++) step();
        vectors++;
        if (mix_valid !== 1'b1 || mix_out !== want[p]) begin
          errors++; $display("FAIL saturation %h: got valid=%b mix=%h want valid=1 mix=%h", pats[p], mix_valid, mix_out, want[p]);
        end
        $display("saturation voices=%h: mix=%h", pats[p], mix_out);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 160; c++) begin
      for (int j = 0; j < 4; j++) vin[j] = 12'($urandom_range(0, 4095));
      gain_we   = ($urandom_range(0, 3) == 0);
      gain_addr = 2'($urandom_range(0, 3));
      gain_data = 4'($urandom_range(0, 15));
      step();
      vectors++;
      if (mix_valid !== exp_valid) begin
        errors++; $display("FAIL random_valid cycle %0d: got %b want %b", c, mix_valid, exp_valid);
      end
      if (exp_valid) begin
        vectors++;
        if (mix_out !== exp_mix) begin
          errors++; $display("FAIL random_mix cycle %0d: got %h want %h", c, mix_out, exp_mix);
        end
        $display("random frame @%0d: mix=%h", c, mix_out);
      end
    end
    gain_we = 1'b0;
  endtask

  task automatic test_gain_timing();
    logic [11:0] want [2];
    want[0] = 12'hD00;
    want[1] = 12'hB00;
    for (int k = 0; k < 4; k++) wr_gain(k, 4);
    vin[0] = 12'h900; vin[1] = 12'h900; vin[2] = 12'hA00; vin[3] = 12'h900;
    align();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        if (f == 0 && k == 2) begin
          gain_we = 1'b1; gain_addr = 2'd2; gain_data = 4'd0;
        end
        step();
        gain_we = 1'b0;
      end
      vectors++;
      if (mix_valid !== 1'b1 || mix_out !== want[f] || mix_out !== exp_mix) begin
        errors++; $display("FAIL gain_timing frame %0d: got valid=%b mix=%h want valid=1 mix=%h", f, mix_valid, mix_out, want[f]);
      end
      $display("gain_timing frame %0d: mix=%h", f, mix_out);
    end
    // Reset in phase 2 discards the frame in flight.
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (mix_out !== 12'h800 || mix_valid !== 1'b0) begin
      errors++; $display("FAIL midframe_reset: got valid=%b mix=%h want valid=0 mix=800", mix_valid, mix_out);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      vectors++;
      if (mix_valid !== (i == 4)) begin
        errors++; $display("FAIL midframe_valid edge %0d: got %b want %b", i, mix_valid, i == 4);
      end
    end
    vectors++;
    if (mix_out !== 12'h940 || mix_out !== exp_mix) begin
      errors++; $display("FAIL midframe_mix: got %h want 940", mix_out);
    end
    $display("midframe reset: first frame after reset mix=%h", mix_out);
  endtask

  task automatic test_dsm();
    logic [11:0] lvl [2];
    int          want_ones [2];
    int          ones;
    lvl[0] = 12'hC00; want_ones[0] = DSM_EN ? 3072 : 0;
    lvl[1] = 12'h000; want_ones[1] = 0;
    for (int p = 0; p < 2; p++) begin
      set_all(lvl[p]);
      rst = 1'b1;
      step();
      rst = 1'b0;
      ones = 0;
      for (int c = 1; c <= 4200; c++) begin
        step();
        vectors++;
        if (dac_out !== exp_dac) begin
          errors++; $display("FAIL dsm_bit level=%h cycle %0d: got %b want %b", lvl[p], c, dac_out, exp_dac);
        end
        if (c > 104 && dac_out === 1'b1) ones++;
      end
      vectors++;
      if (ones !== want_ones[p]) begin
        errors++; $display("FAIL dsm_density level=%h: got %0d ones want %0d per 4096", lvl[p], ones, want_ones[p]);
      end
      $display("dsm level=%h: %0d ones in 4096 cycles", lvl[p], ones);
    end
  endtask

  initial begin
    rst       = 1'b1;
    gain_we   = 1'b0;
    gain_addr = 2'd0;
    gain_data = 4'd0;
    ph        = 0;
    ds_low    = 0;
    exp_mix   = 12'h800;
    exp_valid = 1'b0;
    exp_dac   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      gm[k]  = 1;
      sg[k]  = 1;
      smp[k] = 12'h800;
    end
    set_all(12'h800);

    test_reset();
    test_unity_max();
    test_single_voice();
    test_saturation();
    test_random();
    test_gain_timing();
    test_dsm();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
